// File: rtl/fifo_ctl_pkg.sv
// fifo_ctl_pkg: shared sizing helpers for fifo_ctl; FIFO_ERR_EN is undefined by default
package fifo_ctl_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 2;
    localparam int AFM_DEF = 2;
    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction
    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction
    function automatic int afl_thr(input int aw, input int afm);
        return depth(aw) - afm;
    endfunction
endpackage

// File: rtl/fifo_ctl_if.sv
// fifo_ctl_if: push/pop and status bundle between a FIFO user (master) and fifo_ctl (slave)
interface fifo_ctl_if
    import fifo_ctl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          wre_i;
    logic [DW-1:0] dat_i;
    logic          rde_i;
    logic [DW-1:0] dat_o;
    logic          emp_o;
    logic          ful_o;
    logic          afl_o;
    logic [AW:0]   cnt_o;
    modport master(output wre_i, dat_i, rde_i, input dat_o, emp_o, ful_o, afl_o, cnt_o);
    modport slave(input wre_i, dat_i, rde_i, output dat_o, emp_o, ful_o, afl_o, cnt_o);
endinterface

// File: rtl/fifo_ctl.sv
// fifo_ctl: FWFT FIFO controller driving an external dual-port RAM; FIFO_ERR_EN adds sticky ovf_o/udf_o
module fifo_ctl
    import fifo_ctl_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int AFM = AFM_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    fifo_ctl_if.slave     f,
    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_wre_o,
    output logic [AW-1:0] ram_xadr_o,
    input  logic [DW-1:0] ram_xdat_i
`ifdef FIFO_ERR_EN
    ,
    output logic          ovf_o,
    output logic          udf_o
`endif
);
    localparam int PW = ptr_w(AW);
    localparam logic [PW-1:0] FULL = PW'(depth(AW));
    localparam logic [PW-1:0] AFT = PW'(afl_thr(AW, AFM));
    logic [PW-1:0] wptr, rptr, cnt, cnt_nxt;
    logic emp, ful, afl, push_ok, pop_ok;
    assign push_ok = ena_i & f.wre_i & ~ful;
    assign pop_ok = ena_i & f.rde_i & ~emp;
    // Flags look only at registered state, so a full FIFO rejects a push even when popped in the same cycle.
    always_comb begin
        cnt_nxt = (push_ok & ~pop_ok) ? cnt + 1'b1 : (pop_ok & ~push_ok) ? cnt - 1'b1 : cnt;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            emp  <= 1'b1;
            ful  <= 1'b0;
            afl  <= 1'b0;
        end else begin
            wptr <= wptr + PW'(push_ok);
            rptr <= rptr + PW'(pop_ok);
            cnt  <= cnt_nxt;
            emp  <= cnt_nxt == '0;
            ful  <= cnt_nxt == FULL;
            afl  <= cnt_nxt >= AFT;
        end
    end
`ifdef FIFO_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            ovf_o <= ovf_o | (ena_i & f.wre_i & ful);
            udf_o <= udf_o | (ena_i & f.rde_i & emp);
        end
    end
`endif
    assign ram_adr_o  = wptr[AW-1:0];
    assign ram_xadr_o = rptr[AW-1:0];
    assign ram_dat_o  = f.dat_i;
    assign ram_wre_o  = push_ok;
    assign f.dat_o    = ram_xdat_i;
    assign f.cnt_o    = cnt;
    assign f.emp_o    = emp;
    assign f.ful_o    = ful;
    assign f.afl_o    = afl;
endmodule

// File: tb/tb_fifo_ctl.sv
// tb_fifo_ctl: scoreboard bench for fifo_ctl with a behavioural RAM beside it; honours FIFO_ERR_EN
module tb_fifo_ctl;
    import fifo_ctl_pkg::*;
    localparam int AW = 5;
    localparam int DW = 2;
    localparam int AFM = 2;
    localparam int D = 32;
    logic clk_i = 1'b0;
    logic rst_i, ena_i;
    logic [AW-1:0] ram_adr, ram_xadr;
    logic [DW-1:0] ram_dat, ram_xdat;
    logic ram_wre;
    logic [DW-1:0] mem [D];
`ifdef FIFO_ERR_EN
    logic ovf, udf;
`endif
    logic [DW-1:0] q [$];
    logic [AW:0] wp, rp;
    logic e_ovf, e_udf;
    int checks = 0;
    int errors = 0;
    always #5 clk_i = ~clk_i;
    fifo_ctl_if #(.AW(AW), .DW(DW)) f ();
    fifo_ctl #(.AW(AW), .DW(DW), .AFM(AFM)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ena_i(ena_i),
        .f(f),
        .ram_adr_o(ram_adr),
        .ram_dat_o(ram_dat),
        .ram_wre_o(ram_wre),
        .ram_xadr_o(ram_xadr),
        .ram_xdat_i(ram_xdat)
`ifdef FIFO_ERR_EN
        ,
        .ovf_o(ovf),
        .udf_o(udf)
`endif
    );
    always @(posedge clk_i) if (ram_wre) mem[ram_adr] <= ram_dat;
    assign ram_xdat = mem[ram_xadr];

    task automatic model_clear();
        q.delete();
        wp = '0;
        rp = '0;
        e_ovf = 1'b0;
        e_udf = 1'b0;
    endtask

    // One clock of stimulus, called and returning at a falling edge; scoreboard compares head on every cycle.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        logic push, pop;
        f.wre_i = w;
        f.dat_i = d;
        f.rde_i = r;
        #1;
        push = ena_i & w & (q.size() < D);
        pop = ena_i & r & (q.size() > 0);
        e_ovf = e_ovf | (ena_i & w & (q.size() == D));
        e_udf = e_udf | (ena_i & r & (q.size() == 0));
        checks++;
        if (ram_wre !== push) begin errors++; $display("FAIL ram_wre got %b want %b", ram_wre, push); end
        checks++;
        if (ram_adr !== wp[AW-1:0]) begin errors++; $display("FAIL ram_adr got %0d want %0d", ram_adr, wp[AW-1:0]); end
        checks++;
        if (ram_xadr !== rp[AW-1:0]) begin errors++; $display("FAIL ram_xadr got %0d want %0d", ram_xadr, rp[AW-1:0]); end
        if (q.size() > 0) begin
            checks++;
            if (f.dat_o !== q[0]) begin errors++; $display("FAIL head got %0d want %0d", f.dat_o, q[0]); end
        end
        @(posedge clk_i);
        if (pop) begin void'(q.pop_front()); rp = rp + 1'b1; end
        if (push) begin q.push_back(d); wp = wp + 1'b1; end
        @(negedge clk_i);
        checks++;
        if (f.cnt_o !== (AW+1)'(q.size())) begin errors++; $display("FAIL cnt got %0d want %0d", f.cnt_o, q.size()); end
        checks++;
        if ({f.emp_o, f.ful_o, f.afl_o} !== {q.size() == 0, q.size() == D, q.size() >= D - AFM})
            begin errors++; $display("FAIL flags emp/ful/afl got %b%b%b size %0d", f.emp_o, f.ful_o, f.afl_o, q.size()); end
`ifdef FIFO_ERR_EN
        checks++;
        if ({ovf, udf} !== {e_ovf, e_udf}) begin errors++; $display("FAIL err got %b%b want %b%b", ovf, udf, e_ovf, e_udf); end
`endif
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        f.wre_i = 1'b0;
        f.rde_i = 1'b0;
        f.dat_i = '0;
        ena_i = 1'b1;
        do_reset();
        @(negedge clk_i);
        checks++;
        if ({f.emp_o, f.ful_o, f.afl_o} !== 3'b100) begin errors++; $display("FAIL reset flags got %b%b%b want 100", f.emp_o, f.ful_o, f.afl_o); end
        checks++;
        if (f.cnt_o !== 6'd0) begin errors++; $display("FAIL reset cnt got %0d want 0", f.cnt_o); end
        checks++;
        if (ram_wre !== 1'b0) begin errors++; $display("FAIL reset ram_wre got %b want 0", ram_wre); end
    endtask

    task automatic test_order();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, DW'(i), 1'b0);
            if (i == 0) begin
                checks++;
                if (f.emp_o !== 1'b0 || f.dat_o !== 2'd0) begin errors++; $display("FAIL first push emp %b dat %0d want 0 0", f.emp_o, f.dat_o); end
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
        checks++;
        if (f.emp_o !== 1'b1) begin errors++; $display("FAIL drain emp got %b want 1", f.emp_o); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            cyc(1'b1, DW'(i * 3), 1'b0);
            checks++;
            if (f.afl_o !== (i >= 30) || f.ful_o !== (i == 32))
                begin errors++; $display("FAIL fill %0d afl %b ful %b", i, f.afl_o, f.ful_o); end
        end
        cyc(1'b1, 2'd1, 1'b0);
        checks++;
        if (f.cnt_o !== 6'd32) begin errors++; $display("FAIL overpush cnt got %0d want 32", f.cnt_o); end
`ifdef FIFO_ERR_EN
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf got %b want 1", ovf); end
`endif
    endtask

    task automatic test_pushpop_edges();
        cyc(1'b1, 2'd2, 1'b1);
        checks++;
        if (f.cnt_o !== 6'd31 || f.ful_o !== 1'b0) begin errors++; $display("FAIL full pushpop cnt %0d ful %b want 31 0", f.cnt_o, f.ful_o); end
        while (q.size() > 0) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 2'd2, 1'b1);
        checks++;
        if (f.cnt_o !== 6'd1 || f.dat_o !== 2'd2) begin errors++; $display("FAIL empty pushpop cnt %0d dat %0d want 1 2", f.cnt_o, f.dat_o); end
        cyc(1'b0, '0, 1'b1);
    endtask

    task automatic test_stall();
        cyc(1'b1, 2'd3, 1'b0);
        ena_i = 1'b0;
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1);
        checks++;
        if (f.cnt_o !== 6'd1) begin errors++; $display("FAIL stall cnt got %0d want 1", f.cnt_o); end
        ena_i = 1'b1;
        cyc(1'b0, '0, 1'b1);
    endtask

    task automatic test_wrap();
        int wraps = 0;
        for (int i = 0; i < 100; i++) begin
            logic [AW-1:0] pa;
            pa = ram_adr;
            cyc(1'($urandom_range(1)), DW'($urandom), 1'($urandom_range(1)));
            if (pa == 5'd31 && ram_adr == 5'd0) wraps++;
        end
        while (wp[AW-1:0] != 0) cyc(1'b1, 2'd1, 1'b1);
        cyc(1'b1, 2'd2, 1'b1);
        checks++;
        if (ram_adr !== 5'd1) begin errors++; $display("FAIL wrap adr got %0d want 1", ram_adr); end
    endtask

    task automatic test_reset_mid();
        while (q.size() < 17) cyc(1'b1, DW'(q.size()), 1'b0);
        while (q.size() > 17) cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 1'b0);
        checks++;
        if (f.cnt_o !== 6'd17) begin errors++; $display("FAIL pre-reset cnt got %0d want 17", f.cnt_o); end
        ena_i = 1'b0;
        do_reset();
        checks++;
        if (f.cnt_o !== 6'd0 || f.emp_o !== 1'b1 || f.ful_o !== 1'b0 || f.afl_o !== 1'b0)
            begin errors++; $display("FAIL mid reset cnt %0d emp %b ful %b afl %b", f.cnt_o, f.emp_o, f.ful_o, f.afl_o); end
`ifdef FIFO_ERR_EN
        checks++;
        if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL mid reset err %b%b want 00", ovf, udf); end
`endif
        ena_i = 1'b1;
        checks++;
        if (ram_adr !== 5'd0 || ram_xadr !== 5'd0) begin errors++; $display("FAIL mid reset ptrs %0d %0d want 0 0", ram_adr, ram_xadr); end
        test_order();
    endtask

    initial begin
        rst_i = 1'b1;
        ena_i = 1'b1;
        model_clear();
        @(negedge clk_i);
        test_reset();
        test_order();
        test_fill();
        test_pushpop_edges();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_ctl.md
Name: fifo_ctl

Overview:
Synchronous FIFO controller that sits directly upstream of the dual-port RAM. It drives the RAM's read/write port A as the write side and its read-only port X as the read side. It consumes the RAM's asynchronous port-X read data and presents it as a first-word-fall-through (FWFT) output. It owns the pointers, occupancy count and status flags; storage stays in the RAM instance beside it.

Parameters:
AW, 5, address width; depth = 1<<AW entries (32).
DW, 2, data width; must equal the RAM's DW.
AFM, 2, almost-full margin; afl_o asserts when cnt_o >= (1<<AW) - AFM.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
ena_i  in  1  global enable/stall; when 0, no state changes and no RAM writes.
wre_i  in  1  push request.
dat_i  in  DW  push data.
rde_i  in  1  pop request.
dat_o  out  DW  head-of-FIFO data (FWFT); valid only when emp_o=0.
emp_o  out  1  empty flag.
ful_o  out  1  full flag.
afl_o  out  1  almost-full flag.
cnt_o  out  AW+1  occupancy, 0..(1<<AW).
ram_adr_o  out  AW  to RAM port A address; equals write pointer.
ram_dat_o  out  DW  to RAM port A data; equals dat_i.
ram_wre_o  out  1  to RAM port A write enable.
ram_xadr_o  out  AW  to RAM port X address; equals read pointer.
ram_xdat_i  in  DW  from RAM port X data.

Behaviour:
- push_ok = ena_i & wre_i & ~ful_o.
- pop_ok = ena_i & rde_i & ~emp_o.
- All flags are computed from the current registered state, never from same-cycle requests.
- ram_wre_o = push_ok (combinational). ram_dat_o = dat_i. dat_o = ram_xdat_i (combinational pass-through).
- Pointers wptr and rptr are AW+1 bits wide. Each wraps naturally modulo 2^(AW+1). The low AW bits drive ram_adr_o and ram_xadr_o.
- cnt_o next value:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - unchanged when both or neither occur.
- emp_o, ful_o and afl_o are registered and updated from the next count:
  - emp_o = (cnt==0).
  - ful_o = (cnt==1<<AW).
  - afl_o = (cnt >= (1<<AW)-AFM).
- Latency: a word pushed in cycle N is visible on dat_o, with emp_o=0, in cycle N+1. A pop in cycle N presents the next word in cycle N+1.
- Simultaneous push+pop, non-empty and non-full: both accepted; count unchanged.
- Push+pop while empty: push accepted, pop ignored; count becomes 1.
- Push+pop while full: pop accepted, push rejected; count becomes (1<<AW)-1. The rejected write is not presented to the RAM.
- Push when full or pop when empty is dropped silently; state is unchanged.
- ena_i=0: pointers, count and flags hold; ram_wre_o=0.
- Reset, including mid-operation: wptr=rptr=0, cnt_o=0, emp_o=1, ful_o=0, afl_o=0; error flags cleared. RAM contents are not cleared and are logically discarded. rst_i takes priority over ena_i and all requests.
- No state machine beyond pointer/count registers; the flags are the state.

Optional Feature:
FIFO_ERR_EN.
- Defined: adds outputs ovf_o and udf_o (1 bit each, reset 0).
  - ovf_o sets sticky on ena_i & wre_i & ful_o.
  - udf_o sets sticky on ena_i & rde_i & emp_o.
  - Both are cleared only by rst_i.
- Undefined: the ports are absent and no error logic is built. All other behaviour is identical.

Decomposition:
- Shared package/include:
  - depth constant derivation (1<<AW).
  - pointer width AW+1.
  - almost-full threshold expression.
  - FIFO_ERR_EN default (undefined).
- No sub-module inside fifo_ctl. The RAM is instantiated beside it by the parent.
- A thin fifo_top (fifo_ctl + RAM) is built for verification only.

Test Plan:
- Reset then idle, AW=5: emp_o=1, ful_o=0, afl_o=0, cnt_o=0, ram_wre_o=0.
- Push 0,1,2,3 (DW=2) on consecutive cycles, then pop 4: dat_o reads 0,1,2,3 in order; emp_o deasserts one cycle after the first push and reasserts after the 4th pop.
- Fill to 32: afl_o rises when cnt_o=30 and ful_o when cnt_o=32. A 33rd push gives ram_wre_o=0 and count held; ovf_o=1 if FIFO_ERR_EN is defined.
- Full plus simultaneous push+pop: cnt_o goes 32 to 31 and ful_o drops. Empty plus simultaneous push+pop: cnt_o goes 0 to 1 and dat_o equals the pushed word.
- Wrap-around: 100 cycles of random push/pop at 50% each: scoreboard matches, and ram_adr_o/ram_xadr_o wrap 31 to 0 correctly.
- Assert rst_i with cnt_o=17 and ena_i=0: next cycle cnt_o=0, emp_o=1 and the error flags clear. The subsequent push/pop sequence behaves as from a fresh reset.
